// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU package: PC select constants, fetch FSM states and fault encodings.
package instr_fetch_unit_pkg;

   // Next-PC select used by the control unit
   localparam logic [1:0] PC_4      = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JAL    = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StDrain,
      StDone,
      StFault
   } fetch_state_e;

   typedef enum logic [1:0] {
      CauseNone       = 2'b00,
      CauseMisaligned = 2'b01,
      CauseTimeout    = 2'b10,
      CauseReserved   = 2'b11
   } fault_cause_e;

   function automatic logic word_aligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between fetch unit and memory.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_timeout_counter.sv
// Saturating cycle counter; expired flags the enabled cycle that reaches LIMIT.
module fetch_timeout_counter #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic arst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CntW = $clog2(LIMIT + 1);
   localparam logic [CntW-1:0] LimitVal   = CntW'(LIMIT);
   localparam logic [CntW-1:0] LimitMinus = CntW'(LIMIT - 1);

   logic [CntW-1:0] count_q;

   // Count enabled cycles, holding at LIMIT instead of wrapping
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && (count_q < LimitVal)) begin
         count_q <= count_q + CntW'(1);
      end
   end

   // High in the cycle whose increment brings the count to LIMIT
   always_comb begin
      expired = enable & ~clear & (count_q >= LimitMinus);
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding fetch, flush/redirect, timeout and alignment faults.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  fetch_en,
   input  logic                  flush,
   input  logic [31:0]           pc,
   instr_fetch_unit_if.master    imem,
   output logic [31:0]           instr,
   output logic                  instr_valid,
   output logic                  fetch_busy,
   output logic                  fault,
   output logic [1:0]            fault_cause
);

   fetch_state_e state_q;
   fault_cause_e cause_q;
   logic [31:0]  addr_q;
   logic [31:0]  instr_q;
   logic         fault_q;
   logic         cnt_clear;
   logic         cnt_en;
   logic         cnt_expired;

   // Restart the timeout whenever a wait phase (WAIT or DRAIN) begins
   always_comb begin
      cnt_clear = ((state_q == StReq) & imem.imem_gnt) | ((state_q == StWait) & flush);
      cnt_en    = ((state_q == StWait) | (state_q == StDrain)) & ~imem.imem_rvalid;
   end

   fetch_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .arst_n  (arst_n),
      .clear   (cnt_clear),
      .enable  (cnt_en),
      .expired (cnt_expired)
   );

   // Fetch FSM with registered address, instruction and fault outputs
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         instr_q <= '0;
         fault_q <= 1'b0;
         cause_q <= CauseNone;
      end else begin
         case (state_q)
            StIdle: begin
               if (!flush && fetch_en) begin
                  if (!word_aligned(pc)) begin
                     state_q <= StFault;
                     fault_q <= 1'b1;
                     cause_q <= CauseMisaligned;
                  end else begin
                     addr_q  <= pc;
                     state_q <= StReq;
                  end
               end
            end
            StReq: begin
               // A granted request must still be drained even when flushed
               if (imem.imem_gnt) begin
                  state_q <= flush ? StDrain : StWait;
               end else if (flush) begin
                  state_q <= StIdle;
               end
            end
            StWait: begin
               if (flush) begin
                  state_q <= StDrain;
               end else if (imem.imem_rvalid) begin
                  instr_q <= imem.imem_rdata;
                  state_q <= StDone;
               end else if (cnt_expired) begin
                  state_q <= StFault;
                  fault_q <= 1'b1;
                  cause_q <= CauseTimeout;
               end
            end
            StDrain: begin
               // Response is discarded; a lost response times out silently
               if (imem.imem_rvalid || cnt_expired) begin
                  state_q <= StIdle;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            StFault: begin
               if (flush) begin
                  state_q <= StIdle;
                  fault_q <= 1'b0;
                  cause_q <= CauseNone;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Outputs decoded from state and registers
   always_comb begin
      imem.imem_req  = (state_q == StReq);
      imem.imem_addr = addr_q;
      instr          = instr_q;
      instr_valid    = (state_q == StDone) & ~flush;
      fetch_busy     = (state_q != StIdle);
      fault          = fault_q;
      fault_cause    = cause_q;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: directed vector table, multi-cycle sequences, random vs. reference model.
module tb_instr_fetch_unit;

   localparam int unsigned T = 16;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        fetch_en;
   logic        flush;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fetch_busy;
   logic        fault;
   logic [1:0]  fault_cause;

   instr_fetch_unit_if imem_bus ();

   instr_fetch_unit #(
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .fetch_en    (fetch_en),
      .flush       (flush),
      .pc          (pc),
      .imem        (imem_bus),
      .instr       (instr),
      .instr_valid (instr_valid),
      .fetch_busy  (fetch_busy),
      .fault       (fault),
      .fault_cause (fault_cause)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        fe;
      logic        fl;
      logic [31:0] pc;
      logic        gnt;
      logic        rv;
      logic [31:0] rd;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] instr;
      logic        busy;
      logic        fault;
      logic [1:0]  cause;
   } vec_t;

   vec_t vecs[23];

   function automatic vec_t mk(input logic fe, input logic fl, input logic [31:0] p,
                               input logic g, input logic rv, input logic [31:0] rd,
                               input logic req, input logic [31:0] addr, input logic valid,
                               input logic [31:0] ins, input logic busy, input logic flt,
                               input logic [1:0] cause);
      vec_t v;
      v.fe = fe; v.fl = fl; v.pc = p; v.gnt = g; v.rv = rv; v.rd = rd;
      v.req = req; v.addr = addr; v.valid = valid; v.instr = ins;
      v.busy = busy; v.fault = flt; v.cause = cause;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] ins, input logic busy,
                             input logic flt, input logic [1:0] cause);
      chk({tag, ".imem_req"},    {31'b0, imem_bus.imem_req}, {31'b0, req});
      chk({tag, ".imem_addr"},   imem_bus.imem_addr, addr);
      chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, valid});
      chk({tag, ".instr"},       instr, ins);
      chk({tag, ".fetch_busy"},  {31'b0, fetch_busy}, {31'b0, busy});
      chk({tag, ".fault"},       {31'b0, fault}, {31'b0, flt});
      chk({tag, ".fault_cause"}, {30'b0, fault_cause}, {30'b0, cause});
   endtask

   task automatic set_in(input logic fe, input logic fl, input logic [31:0] p,
                         input logic g, input logic rv, input logic [31:0] rd);
      fetch_en = fe; flush = fl; pc = p;
      imem_bus.imem_gnt = g; imem_bus.imem_rvalid = rv; imem_bus.imem_rdata = rd;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: phase of the single outstanding fetch plus elapsed wait cycles
   localparam int PIdle = 0, PReq = 1, PWait = 2, PDrain = 3, PDone = 4, PFault = 5;
   int          m_phase;
   int          m_waited;
   logic [31:0] m_addr;
   logic [31:0] m_instr;
   logic        m_fault;
   logic [1:0]  m_cause;

   task automatic model_reset();
      m_phase = PIdle; m_waited = 0; m_addr = 0; m_instr = 0; m_fault = 0; m_cause = 0;
   endtask

   task automatic model_step();
      logic g, rv;
      g  = imem_bus.imem_gnt;
      rv = imem_bus.imem_rvalid;
      if (m_phase == PIdle) begin
         if (!flush && fetch_en) begin
            if (pc % 4 != 0) begin
               m_phase = PFault; m_fault = 1; m_cause = 2'd1;
            end else begin
               m_addr = pc; m_phase = PReq;
            end
         end
      end else if (m_phase == PReq) begin
         if (g) begin
            m_phase = flush ? PDrain : PWait; m_waited = 0;
         end else if (flush) begin
            m_phase = PIdle;
         end
      end else if (m_phase == PWait) begin
         if (flush) begin
            m_phase = PDrain; m_waited = 0;
         end else if (rv) begin
            m_instr = imem_bus.imem_rdata; m_phase = PDone;
         end else begin
            m_waited++;
            if (m_waited >= T) begin
               m_phase = PFault; m_fault = 1; m_cause = 2'd2;
            end
         end
      end else if (m_phase == PDrain) begin
         if (rv) m_phase = PIdle;
         else begin
            m_waited++;
            if (m_waited >= T) m_phase = PIdle;
         end
      end else if (m_phase == PDone) begin
         m_phase = PIdle;
      end else if (flush) begin
         m_phase = PIdle; m_fault = 0; m_cause = 0;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Directed vectors: each row is one cycle's inputs and outputs sampled in that cycle
      vecs[0]  = mk(1, 0, 32'h10, 0, 0, 0,            0, 32'h00, 0, 32'h00, 0, 0, 0);
      vecs[1]  = mk(0, 0, 32'h10, 1, 0, 0,            1, 32'h10, 0, 32'h00, 1, 0, 0);
      vecs[2]  = mk(0, 0, 32'h10, 0, 1, 32'h93,       0, 32'h10, 0, 32'h00, 1, 0, 0);
      vecs[3]  = mk(0, 0, 32'h10, 0, 0, 0,            0, 32'h10, 1, 32'h93, 1, 0, 0);
      vecs[4]  = mk(0, 0, 32'h10, 0, 0, 0,            0, 32'h10, 0, 32'h93, 0, 0, 0);
      vecs[5]  = mk(1, 0, 32'h06, 0, 0, 0,            0, 32'h10, 0, 32'h93, 0, 0, 0);
      vecs[6]  = mk(0, 0, 32'h06, 0, 0, 0,            0, 32'h10, 0, 32'h93, 1, 1, 1);
      vecs[7]  = mk(1, 0, 32'h20, 1, 0, 0,            0, 32'h10, 0, 32'h93, 1, 1, 1);
      vecs[8]  = mk(0, 1, 32'h20, 0, 0, 0,            0, 32'h10, 0, 32'h93, 1, 1, 1);
      vecs[9]  = mk(0, 0, 32'h20, 0, 0, 0,            0, 32'h10, 0, 32'h93, 0, 0, 0);
      vecs[10] = mk(1, 0, 32'h40, 0, 0, 0,            0, 32'h10, 0, 32'h93, 0, 0, 0);
      vecs[11] = mk(0, 0, 32'h40, 1, 0, 0,            1, 32'h40, 0, 32'h93, 1, 0, 0);
      vecs[12] = mk(0, 1, 32'h40, 0, 0, 0,            0, 32'h40, 0, 32'h93, 1, 0, 0);
      vecs[13] = mk(0, 0, 32'h40, 0, 0, 0,            0, 32'h40, 0, 32'h93, 1, 0, 0);
      vecs[14] = mk(0, 0, 32'h40, 0, 1, 32'hDEADBEEF, 0, 32'h40, 0, 32'h93, 1, 0, 0);
      vecs[15] = mk(0, 0, 32'h40, 0, 0, 0,            0, 32'h40, 0, 32'h93, 0, 0, 0);
      vecs[16] = mk(1, 0, 32'h44, 0, 0, 0,            0, 32'h40, 0, 32'h93, 0, 0, 0);
      vecs[17] = mk(0, 0, 32'h44, 1, 0, 0,            1, 32'h44, 0, 32'h93, 1, 0, 0);
      vecs[18] = mk(0, 0, 32'h44, 0, 1, 32'h13,       0, 32'h44, 0, 32'h93, 1, 0, 0);
      vecs[19] = mk(0, 1, 32'h44, 0, 0, 0,            0, 32'h44, 0, 32'h13, 1, 0, 0);
      vecs[20] = mk(0, 0, 32'h44, 0, 0, 0,            0, 32'h44, 0, 32'h13, 0, 0, 0);
      vecs[21] = mk(0, 0, 32'h44, 0, 1, 32'hFFFF,     0, 32'h44, 0, 32'h13, 0, 0, 0);
      vecs[22] = mk(0, 0, 32'h44, 0, 0, 0,            0, 32'h44, 0, 32'h13, 0, 0, 0);

      arst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      arst_n = 1'b1;
      #3;
      check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
      cyc();

      for (int i = 0; i < 23; i++) begin
         set_in(vecs[i].fe, vecs[i].fl, vecs[i].pc, vecs[i].gnt, vecs[i].rv, vecs[i].rd);
         #3;
         check_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                    vecs[i].instr, vecs[i].busy, vecs[i].fault, vecs[i].cause);
         cyc();
      end

      // Timeout: grant, then no response for T WAIT cycles
      set_in(1, 0, 32'h80, 0, 0, 0); #3; cyc();
      set_in(0, 0, 32'h80, 1, 0, 0); #3;
      chk("to.req", {31'b0, imem_bus.imem_req}, 32'd1);
      cyc();
      for (int i = 0; i < T; i++) begin
         set_in(0, 0, 32'h80, 0, 0, 0); #3;
         chk($sformatf("to.wait%0d.fault", i), {31'b0, fault}, 32'd0);
         chk($sformatf("to.wait%0d.busy", i), {31'b0, fetch_busy}, 32'd1);
         cyc();
      end
      set_in(0, 0, 32'h80, 0, 1, 32'h5555); #3;
      check_outs("to.fault", 0, 32'h80, 0, 32'h13, 1, 1, 2);
      cyc();
      set_in(0, 0, 32'h80, 0, 0, 0); #3;
      check_outs("to.late", 0, 32'h80, 0, 32'h13, 1, 1, 2);
      set_in(0, 1, 32'h80, 0, 0, 0); cyc();
      set_in(0, 0, 32'h80, 0, 0, 0); #3;
      check_outs("to.clear", 0, 32'h80, 0, 32'h13, 0, 0, 0);
      cyc();

      // Grant stall: request held, pc changes and a second fetch_en ignored
      set_in(1, 0, 32'h100, 0, 0, 0); #3; cyc();
      for (int i = 0; i < 5; i++) begin
         set_in(i == 2, 0, $urandom & 32'hFFFF_FFFC, 0, 0, 0); #3;
         chk($sformatf("stall%0d.req", i), {31'b0, imem_bus.imem_req}, 32'd1);
         chk($sformatf("stall%0d.addr", i), imem_bus.imem_addr, 32'h100);
         cyc();
      end
      set_in(0, 0, 32'h200, 1, 0, 0); #3;
      chk("stall.gnt.addr", imem_bus.imem_addr, 32'h100);
      cyc();
      set_in(0, 0, 32'h200, 0, 1, 32'hABC); #3; cyc();
      set_in(0, 0, 32'h200, 0, 0, 0); #3;
      check_outs("stall.done", 0, 32'h100, 1, 32'hABC, 1, 0, 0);
      cyc();

      // Asynchronous reset in WAIT, then a stray response after release
      set_in(1, 0, 32'h300, 0, 0, 0); #3; cyc();
      set_in(0, 0, 32'h300, 1, 0, 0); #3; cyc();
      set_in(0, 0, 32'h300, 0, 0, 0); #1;
      arst_n = 1'b0;
      #1;
      check_outs("arst", 0, 0, 0, 0, 0, 0, 0);
      cyc();
      arst_n = 1'b1;
      set_in(0, 0, 32'h300, 0, 1, 32'hCAFE); #3;
      chk("arst.stray.valid", {31'b0, instr_valid}, 32'd0);
      cyc();
      set_in(0, 0, 32'h300, 0, 0, 0); #3;
      check_outs("arst.after", 0, 0, 0, 0, 0, 0, 0);
      cyc();

      // Random traffic against the reference model
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] p;
         p = $urandom;
         if ($urandom_range(7) != 0) p[1:0] = 2'b00;
         set_in($urandom_range(1), $urandom_range(15) == 0, p, $urandom_range(1),
                $urandom_range(3) == 0, $urandom);
         #3;
         check_outs($sformatf("rnd%0d", n), m_phase == PReq, m_addr,
                    (m_phase == PDone) && !flush, m_instr, m_phase != PIdle, m_fault, m_cause);
         model_step();
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
